ecdhe_keyshare_tx: RTL



---
 rtl/ecdhe_keyshare_tx.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/ecdhe_keyshare_tx.sv
// ecdhe_keyshare_tx
// Derives the local ECDHE public key share from the local private key and
// sends it to the peer as a byte-serial frame:
//   HDR_BYTE, 8'h20, 32 key bytes (MSB byte first), XOR checksum (tx_last).
// Key derivation is a simple fixed-latency model: after KEYGEN_CYCLES cycles
// the public key becomes latched_key ^ BASE_POINT.
//
// Stream handshake: a byte moves when tx_valid and tx_ready are both high at
// a rising clock edge. While tx_valid is high and tx_ready is low, tx_data
// and tx_last hold their values and tx_valid stays high. tx_valid, tx_data
// and tx_last are decoded from registered state only, so tx_ready never
// reaches them combinationally.
module ecdhe_keyshare_tx #(
  parameter int unsigned    KEYGEN_CYCLES = 30,
  parameter logic [7:0]     HDR_BYTE      = 8'h5A,
  parameter logic [255:0]   BASE_POINT    = {32{8'hC3}}
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [255:0] private_key,
  output logic         busy,
  output logic [255:0] public_key,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         tx_last,
  output logic         done,
  output logic [2:0]   dbg_state
);

  // Number of key bytes in the frame, also sent as the length byte.
  localparam logic [7:0] KEY_LEN     = 8'h20;
  localparam logic [7:0] KEYGEN_LAST = 8'(KEYGEN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_KEYGEN = 3'd1,
    S_HDR    = 3'd2,
    S_LEN    = 3'd3,
    S_KEY    = 3'd4,
    S_CSUM   = 3'd5
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [255:0] key_q;       // private key captured on accepted start
  logic [7:0]   cycle_cnt;   // key derivation cycle counter
  logic [4:0]   byte_idx;    // index of the key byte being offered
  logic [7:0]   csum;        // running XOR of handshaken key bytes
  logic [7:0]   key_byte;
  logic         hs;
  logic         accept;
  logic         keygen_end;

  // Byte idx of the key, MSB byte first: bits [255-8*idx -: 8].
  // The low bit of that slice is 8*(31-idx) = {~idx, 3'b000}.
  assign key_byte  = public_key[{~byte_idx, 3'b000} +: 8];
  assign hs        = tx_valid & tx_ready;
  assign dbg_state = state;

  // State register; reset abandons any frame in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and stream output decode.
  always_comb begin
    state_nxt  = state;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    tx_last    = 1'b0;
    accept     = 1'b0;
    keygen_end = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_KEYGEN;
        end
      end
      S_KEYGEN: begin
        if (cycle_cnt == KEYGEN_LAST) begin
          keygen_end = 1'b1;
          state_nxt  = S_HDR;
        end
      end
      S_HDR: begin
        tx_valid = 1'b1;
        tx_data  = HDR_BYTE;
        if (tx_ready) begin
          state_nxt = S_LEN;
        end
      end
      S_LEN: begin
        tx_valid = 1'b1;
        tx_data  = KEY_LEN;
        if (tx_ready) begin
          state_nxt = S_KEY;
        end
      end
      S_KEY: begin
        tx_valid = 1'b1;
        tx_data  = key_byte;
        if (tx_ready && (byte_idx == 5'd31)) begin
          state_nxt = S_CSUM;
        end
      end
      S_CSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum;
        tx_last  = 1'b1;
        if (tx_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: key capture, derivation counter, byte index, checksum, status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_q      <= '0;
      public_key <= '0;
      cycle_cnt  <= '0;
      byte_idx   <= '0;
      csum       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      // done is a single-cycle pulse unless re-armed below
      done <= 1'b0;
      if (accept) begin
        key_q     <= private_key;
        cycle_cnt <= '0;
        csum      <= '0;
        busy      <= 1'b1;
      end
      if (state == S_KEYGEN) begin
        cycle_cnt <= cycle_cnt + 8'd1;
        if (keygen_end) begin
          public_key <= key_q ^ BASE_POINT;
        end
      end
      if ((state == S_LEN) && hs) begin
        byte_idx <= '0;
      end
      if ((state == S_KEY) && hs) begin
        csum     <= csum ^ tx_data;
        byte_idx <= byte_idx + 5'd1;
      end
      if ((state == S_CSUM) && hs) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule
